// File: rtl/event_uart_tx_if.sv
// Event-capture / UART-transmit signal bundle between the key scanner and event_uart_tx.
// The scanner side drives eventFlag/eventCode; the transmitter reports line and queue status.
interface event_uart_tx_if;
    logic       eventFlag;
    logic [7:0] eventCode;
    logic       txLine;
    logic       busy;
    logic [4:0] fifoCount;
    logic       overflow;

    modport master (
        output eventFlag, eventCode,
        input  txLine, busy, fifoCount, overflow
    );

    modport slave (
        input  eventFlag, eventCode,
        output txLine, busy, fifoCount, overflow
    );
endinterface

// File: rtl/event_uart_tx.sv
// Queues one entry per rising edge of eventFlag and sends each queued code as an
// 8N1 UART frame, LSB first, BAUD_DIV clocks per bit.
module event_uart_tx #(
    parameter int DEPTH    = 8,
    parameter int BAUD_DIV = 104
) (
    input  logic           clk,
    input  logic           rst,
    event_uart_tx_if.slave bus
);
    localparam int         PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_C   = 5'(DEPTH);
    localparam logic [9:0] BAUD_LAST = 10'(BAUD_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e           state_q, state_d;
    logic [9:0]       baud_q, baud_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             flag_q, flag_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]       count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       mem_q [DEPTH];

    logic rise, full, push, pop, baud_end;

    // The transmitter takes the head entry whenever it sits in IDLE with data waiting.
    assign pop = (state_q == IDLE) && (count_q != 5'd0);

    always_comb begin
        flag_d   = bus.eventFlag;
        rise     = bus.eventFlag & ~flag_q;
        full     = (count_q == DEPTH_C);
        // A pop on the same edge frees a slot, so a full queue still accepts.
        push     = rise & (~full | pop);
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)
            count_d = count_q + 5'd1;
        else if (pop && !push)
            count_d = count_q - 5'd1;
        ovf_d    = ovf_q | (rise & full & ~pop);
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        baud_end  = (baud_q == BAUD_LAST);
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (pop) begin
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = 10'd0;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d    = 10'd0;
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                end else begin
                    baud_d = baud_q + 10'd1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = 10'd0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        // Line takes the next bit on the same edge the shifter advances.
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 10'd1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d  = 10'd0;
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud_q + 10'd1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            baud_q    <= 10'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            tx_q      <= 1'b1;
            flag_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= 5'd0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            flag_q    <= flag_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
        end
    end

    // Storage is left unreset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (rst && push)
            mem_q[wr_ptr_q] <= bus.eventCode;
    end

    assign bus.txLine    = tx_q;
    assign bus.fifoCount = count_q;
    assign bus.overflow  = ovf_q;
    assign bus.busy      = (state_q != IDLE) || (count_q != 5'd0);
endmodule

// File: tb/tb_event_uart_tx.sv
// Randomized and directed bench for event_uart_tx: a queue-level reference model predicts
// line/status every cycle, and a UART decoder checks each frame against a scoreboard.
module tb_event_uart_tx;
    localparam int B = 4;
    localparam int D = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    event_uart_tx_if bus ();

    event_uart_tx #(.DEPTH(D), .BAUD_DIV(B)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int         cyc = 0;
    logic [7:0] m_q[$];
    logic [7:0] exp_frames[$];
    logic [7:0] m_cur = 8'h00;
    int         m_start = 0;
    int         m_next_pop = 0;
    bit         m_active = 0;
    bit         m_prev = 0;
    bit         m_ovf = 0;
    bit         m_rst_edge = 1;
    int         peak = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Queue semantics: transmitter pops when free and data is waiting, one frame is
    // 10*B cycles plus one idle cycle, and a rising edge is kept only if space remains.
    task automatic model_step();
        bit pop;
        bit rise;
        cyc++;
        if (!rst) begin
            m_q.delete();
            exp_frames.delete();
            m_prev = 0; m_ovf = 0; m_active = 0; m_next_pop = 0; m_rst_edge = 1;
        end else begin
            m_rst_edge = 0;
            pop = (cyc >= m_next_pop) && (m_q.size() > 0);
            if (pop) begin
                m_cur = m_q.pop_front();
                m_start = cyc;
                m_active = 1;
                m_next_pop = cyc + 10 * B + 1;
            end
            rise = bus.eventFlag && !m_prev;
            m_prev = bus.eventFlag;
            if (rise) begin
                if (m_q.size() < D) begin
                    m_q.push_back(bus.eventCode);
                    exp_frames.push_back(bus.eventCode);
                end else begin
                    m_ovf = 1;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // cycle-level comparison of all outputs against the model
    initial forever begin
        logic       e_tx;
        logic       e_busy;
        int         off;
        int         b;
        @(negedge clk);
        if (cyc > 0) begin
            e_tx = 1'b1;
            e_busy = (m_q.size() != 0);
            if (m_active) begin
                off = cyc - m_start;
                if (off < 10 * B) begin
                    e_busy = 1'b1;
                    b = off / B;
                    if (b == 0) e_tx = 1'b0;
                    else if (b < 9) e_tx = m_cur[b-1];
                end
            end
            check("outputs{tx,busy,ovf,count}",
                  32'({bus.txLine, bus.busy, bus.overflow, bus.fifoCount}),
                  32'({e_tx, e_busy, m_ovf, 5'(m_q.size())}));
        end
    end

    // UART decoder: samples mid-bit and compares each frame with the scoreboard head
    initial begin
        bit         in_frame = 0;
        int         cnt = 0;
        logic [9:0] fr = '0;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (m_rst_edge) begin
                in_frame = 0;
            end else begin
                if (!in_frame && bus.txLine === 1'b0) begin
                    in_frame = 1;
                    cnt = 0;
                end
                if (in_frame) begin
                    if (cnt % B == B / 2) fr[cnt/B] = bus.txLine;
                    if (cnt == 9 * B + B / 2) begin
                        in_frame = 0;
                        if (exp_frames.size() == 0) begin
                            n_vec++;
                            n_err++;
                            $display("FAIL frame: got unexpected frame 0x%0h, expected none", fr);
                        end else begin
                            e = exp_frames.pop_front();
                            check("frame{stop,data,start}", 32'(fr), 32'({1'b1, e, 1'b0}));
                        end
                    end
                    cnt++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        if (int'(bus.fifoCount) > peak) peak = int'(bus.fifoCount);
    endtask

    task automatic pulse(input logic [7:0] code);
        bus.eventFlag = 1'b1;
        bus.eventCode = code;
        tick();
        bus.eventFlag = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (bus.busy !== 1'b0 && k < budget) begin
            tick();
            k++;
        end
        check("drain_busy", 32'(bus.busy), 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        check("rst_tx", 32'(bus.txLine), 1);
        check("rst_count", 32'(bus.fifoCount), 0);
        check("rst_ovf", 32'(bus.overflow), 0);
        check("rst_busy", 32'(bus.busy), 0);
        rst = 1'b1;
    endtask

    initial begin
        int k;
        bus.eventFlag = 1'b0;
        bus.eventCode = 8'h00;
        do_reset();
        tick();

        // single pulse: latency and frame length
        bus.eventFlag = 1'b1;
        bus.eventCode = 8'h5A;
        tick();
        check("lat_count_N", 32'(bus.fifoCount), 1);
        check("lat_tx_N", 32'(bus.txLine), 1);
        bus.eventFlag = 1'b0;
        tick();
        check("lat_tx_N1", 32'(bus.txLine), 0);
        k = 0;
        while (bus.busy === 1'b1 && k < 100) begin
            tick();
            k++;
        end
        check("busy_drop_cycles", 32'(k), 40);
        tick();

        // held-high flag gives one entry
        peak = 0;
        bus.eventFlag = 1'b1;
        bus.eventCode = 8'h81;
        repeat (20) tick();
        bus.eventFlag = 1'b0;
        check("held_peak", 32'(peak), 1);
        wait_idle(200);

        // three pulses back to back
        pulse(8'h41);
        pulse(8'h82);
        pulse(8'h43);
        wait_idle(300);

        // overflow: ten pulses during the first frame
        peak = 0;
        for (int i = 0; i < 10; i++) pulse(8'(8'h10 + i));
        check("ovf_peak", 32'(peak), 8);
        check("ovf_set", 32'(bus.overflow), 1);
        wait_idle(600);
        check("ovf_sticky", 32'(bus.overflow), 1);
        do_reset();

        // full queue with write on the pop edge
        pulse(8'hC0);
        for (int i = 0; i < 8; i++) pulse(8'(8'hC1 + i));
        check("full_count", 32'(bus.fifoCount), 8);
        k = 0;
        while (cyc + 1 < m_next_pop && k < 100) begin
            tick();
            k++;
        end
        bus.eventFlag = 1'b1;
        bus.eventCode = 8'hEE;
        tick();
        bus.eventFlag = 1'b0;
        check("full_pop_count", 32'(bus.fifoCount), 8);
        check("full_pop_ovf", 32'(bus.overflow), 0);
        wait_idle(600);

        // reset during data bit 3
        pulse(8'h3C);
        pulse(8'h11);
        pulse(8'h22);
        k = 0;
        while (cyc - m_start < 17 && k < 100) begin
            tick();
            k++;
        end
        rst = 1'b0;
        tick();
        check("midrst_tx", 32'(bus.txLine), 1);
        check("midrst_count", 32'(bus.fifoCount), 0);
        check("midrst_busy", 32'(bus.busy), 0);
        rst = 1'b1;
        tick();
        pulse(8'(8'h80 | $urandom_range(0, 63)));
        wait_idle(200);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            bus.eventFlag = ($urandom_range(0, 99) < 25);
            bus.eventCode = 8'($urandom);
            tick();
        end
        bus.eventFlag = 1'b0;
        wait_idle(1000);
        repeat (3) tick();
        check("scoreboard_empty", 32'(exp_frames.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
